// File: rtl/ysyx_23060246_halt_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_23060246_halt_pkg
//   Shared types and helpers for the NPC halt controller.
//   - halt_cause_e : 3-bit cause code reported on halt_cause.
//   - halt_state_e : controller phases (RUN/DRAIN/REPORT/HALTED).
//   - PRIO_*       : bit positions in the raw event vector; a lower index
//                    means a higher priority when several events coincide.
//   - select_cause : picks the winning cause from an event vector.
//   - exit_code_for: builds the exit code reported for a cause.
// ---------------------------------------------------------------------------
package ysyx_23060246_halt_pkg;

  typedef enum logic [2:0] {
    CAUSE_NONE         = 3'd0,
    CAUSE_EBREAK       = 3'd1,
    CAUSE_INST_INVALID = 3'd2,
    CAUSE_AXI_BERR     = 3'd3,
    CAUSE_AXI_RERR     = 3'd4,
    CAUSE_WATCHDOG     = 3'd5
  } halt_cause_e;

  typedef enum logic [1:0] {
    HS_RUN    = 2'd0,
    HS_DRAIN  = 2'd1,
    HS_REPORT = 2'd2,
    HS_HALTED = 2'd3
  } halt_state_e;

  // Event vector layout, highest priority first.
  localparam int unsigned NUM_EVENTS        = 5;
  localparam int unsigned PRIO_AXI_RERR     = 0;
  localparam int unsigned PRIO_AXI_BERR     = 1;
  localparam int unsigned PRIO_INST_INVALID = 2;
  localparam int unsigned PRIO_EBREAK       = 3;
  localparam int unsigned PRIO_WATCHDOG     = 4;

  typedef logic [NUM_EVENTS-1:0] halt_event_t;

  // Fixed-priority pick; the if-chain order is the priority order.
  function automatic halt_cause_e select_cause(input halt_event_t ev);
    halt_cause_e cause;
    if (ev[PRIO_AXI_RERR])          cause = CAUSE_AXI_RERR;
    else if (ev[PRIO_AXI_BERR])     cause = CAUSE_AXI_BERR;
    else if (ev[PRIO_INST_INVALID]) cause = CAUSE_INST_INVALID;
    else if (ev[PRIO_EBREAK])       cause = CAUSE_EBREAK;
    else if (ev[PRIO_WATCHDOG])     cause = CAUSE_WATCHDOG;
    else                            cause = CAUSE_NONE;
    return cause;
  endfunction

  // An ebreak reports the program's a0 (0 = good trap); every other cause
  // reports its own code so a harness can tell failures apart.
  function automatic logic [31:0] exit_code_for(input halt_cause_e cause,
                                                input logic [31:0] a0);
    logic [31:0] code;
    if (cause == CAUSE_EBREAK) code = a0;
    else                       code = {29'b0, cause};
    return code;
  endfunction

endpackage

// File: rtl/ysyx_23060246_halt_ctrl_if.sv
// ---------------------------------------------------------------------------
// ysyx_23060246_halt_ctrl_if
//   AXI status seen by the halt controller.
//   bresp_valid/bresp     : B-channel handshake and write response
//   rresp_valid/rresp     : R-channel handshake and read response
//   axi_outstanding       : count of transactions still in flight
//   master modport        : driven by the core / AXI fabric side
//   slave modport         : consumed by the halt controller
// ---------------------------------------------------------------------------
interface ysyx_23060246_halt_ctrl_if #(
  parameter int unsigned OUTST_W = 4
);

  logic               bresp_valid;
  logic [1:0]         bresp;
  logic               rresp_valid;
  logic [1:0]         rresp;
  logic [OUTST_W-1:0] axi_outstanding;

  modport master (
    output bresp_valid,
    output bresp,
    output rresp_valid,
    output rresp,
    output axi_outstanding
  );

  modport slave (
    input bresp_valid,
    input bresp,
    input rresp_valid,
    input rresp,
    input axi_outstanding
  );

endinterface

// File: rtl/ysyx_23060246_halt_wdog.sv
// ---------------------------------------------------------------------------
// ysyx_23060246_halt_wdog
//   Commit-idle counter. Counts enabled cycles since the last kick and
//   raises expire (combinationally) on the cycle the count reaches
//   WDOG_CYCLES-1. A kick in that same cycle does not suppress expire.
//   WDOG_CYCLES = 0 removes the counter entirely.
//   clock  : clock
//   reset  : synchronous active-high reset
//   enable : count only while high; low clears the count
//   kick   : instruction retired; restarts the count
//   expire : idle limit reached this cycle
// ---------------------------------------------------------------------------
module ysyx_23060246_halt_wdog #(
  parameter int unsigned WDOG_CYCLES = 1000000
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic kick,
  output logic expire
);

  generate
    if (WDOG_CYCLES == 0) begin : g_off
      logic unused_wdog_ports;
      assign unused_wdog_ports = ^{clock, reset, enable, kick};
      assign expire = 1'b0;
    end else begin : g_on
      localparam int unsigned CNT_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WDOG_CYCLES - 1);

      logic [CNT_W-1:0] idle_reg;
      logic [CNT_W-1:0] idle_next;

      assign expire = enable && (idle_reg == CNT_LAST);

      // Wrapping to zero on expire keeps the count in range; the top leaves
      // RUN on expire, which clears it through enable anyway.
      always_comb begin
        idle_next = idle_reg + 1'b1;
        if (!enable || kick || expire) begin
          idle_next = '0;
        end
      end

      always_ff @(posedge clock) begin
        if (reset) begin
          idle_reg <= '0;
        end else begin
          idle_reg <= idle_next;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/ysyx_23060246_halt_ctrl.sv
// ---------------------------------------------------------------------------
// ysyx_23060246_halt_ctrl
//   Central simulation-termination controller for the NPC core. Collects halt
//   events, keeps the highest-priority one, stalls fetch, waits for in-flight
//   AXI traffic to drain (bounded by DRAIN_TIMEOUT), then reports once.
//   Inputs : clock, reset (sync, active-high), ebreak_valid + a0_value,
//            inst_invalid, inst_pc, commit_valid, axi (AXI status, slave).
//   Outputs: fetch_stall (DRAIN onward), halt_valid (REPORT pulse),
//            halted (HALTED level), halt_cause / exit_code / halt_pc
//            (latched at the event cycle), drain_timeout, cycle_count.
//   SIM_REPORT enables the simulation-only banner and $finish in REPORT.
// ---------------------------------------------------------------------------
module ysyx_23060246_halt_ctrl
  import ysyx_23060246_halt_pkg::*;
#(
  parameter int unsigned OUTST_W       = 4,
  parameter int unsigned DRAIN_TIMEOUT = 256,
  parameter int unsigned WDOG_CYCLES   = 1000000,
  parameter bit          SIM_REPORT    = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ebreak_valid,
  input  logic [31:0]           a0_value,
  input  logic                  inst_invalid,
  input  logic [31:0]           inst_pc,
  input  logic                  commit_valid,
  ysyx_23060246_halt_ctrl_if.slave axi,
  output logic                  fetch_stall,
  output logic                  halt_valid,
  output logic                  halted,
  output logic [2:0]            halt_cause,
  output logic [31:0]           exit_code,
  output logic [31:0]           halt_pc,
  output logic                  drain_timeout,
  output logic [63:0]           cycle_count
);

  localparam logic [1:0] ST_RUN    = HS_RUN;
  localparam logic [1:0] ST_DRAIN  = HS_DRAIN;
  localparam logic [1:0] ST_REPORT = HS_REPORT;
  localparam logic [1:0] ST_HALTED = HS_HALTED;

  localparam int unsigned DRAIN_W = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_TIMEOUT - 1);

  logic [1:0]         state_reg,     state_next;
  logic [2:0]         cause_reg,     cause_next;
  logic [31:0]        exit_reg,      exit_next;
  logic [31:0]        pc_reg,        pc_next;
  logic               timeout_reg,   timeout_next;
  logic [DRAIN_W-1:0] drain_cnt_reg, drain_cnt_next;
  logic [63:0]        cycle_reg,     cycle_next;

  logic [OUTST_W-1:0] outstanding;
  halt_event_t        events;
  halt_cause_e        event_cause;
  logic               wdog_enable;
  logic               wdog_expire;

  assign outstanding = axi.axi_outstanding;

  // Only the error bit of each response matters (SLVERR/DECERR).
  logic unused_resp_lsb;
  assign unused_resp_lsb = ^{axi.bresp[0], axi.rresp[0]};

  always_comb begin
    events                    = '0;
    events[PRIO_AXI_RERR]     = axi.rresp_valid & axi.rresp[1];
    events[PRIO_AXI_BERR]     = axi.bresp_valid & axi.bresp[1];
    events[PRIO_INST_INVALID] = inst_invalid;
    events[PRIO_EBREAK]       = ebreak_valid;
    events[PRIO_WATCHDOG]     = wdog_expire;
  end

  assign event_cause = select_cause(events);

  // The watchdog only counts while the core is free-running; leaving RUN
  // clears it so a later reset starts from a clean count.
  assign wdog_enable = (state_reg == ST_RUN);

  ysyx_23060246_halt_wdog #(
    .WDOG_CYCLES (WDOG_CYCLES)
  ) u_wdog (
    .clock  (clock),
    .reset  (reset),
    .enable (wdog_enable),
    .kick   (commit_valid),
    .expire (wdog_expire)
  );

  always_comb begin
    state_next     = state_reg;
    cause_next     = cause_reg;
    exit_next      = exit_reg;
    pc_next        = pc_reg;
    timeout_next   = timeout_reg;
    drain_cnt_next = drain_cnt_reg;
    cycle_next     = cycle_reg;

    case (state_reg)
      ST_RUN: begin
        if (|events) begin
          state_next     = ST_DRAIN;
          cause_next     = event_cause;
          exit_next      = exit_code_for(event_cause, a0_value);
          pc_next        = inst_pc;
          drain_cnt_next = '0;
        end
      end
      ST_DRAIN: begin
        // An empty bus wins over a timeout landing on the same cycle, so
        // drain_timeout only flags a drain that truly never completed.
        if (outstanding == '0) begin
          state_next = ST_REPORT;
        end else if (drain_cnt_reg == DRAIN_LAST) begin
          state_next   = ST_REPORT;
          timeout_next = 1'b1;
        end else begin
          drain_cnt_next = drain_cnt_reg + 1'b1;
        end
      end
      ST_REPORT: begin
        state_next = ST_HALTED;
      end
      default: begin
        state_next = state_reg;
      end
    endcase

    // Cycle counter stops once the report is issued so the reported figure
    // matches what the harness prints; saturate rather than wrap.
    if (((state_reg == ST_RUN) || (state_reg == ST_DRAIN)) && (cycle_reg != '1)) begin
      cycle_next = cycle_reg + 64'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= ST_RUN;
      cause_reg     <= CAUSE_NONE;
      exit_reg      <= '0;
      pc_reg        <= '0;
      timeout_reg   <= 1'b0;
      drain_cnt_reg <= '0;
      cycle_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      cause_reg     <= cause_next;
      exit_reg      <= exit_next;
      pc_reg        <= pc_next;
      timeout_reg   <= timeout_next;
      drain_cnt_reg <= drain_cnt_next;
      cycle_reg     <= cycle_next;
    end
  end

  assign fetch_stall   = (state_reg != ST_RUN);
  assign halt_valid    = (state_reg == ST_REPORT);
  assign halted        = (state_reg == ST_HALTED);
  assign halt_cause    = cause_reg;
  assign exit_code     = exit_reg;
  assign halt_pc       = pc_reg;
  assign drain_timeout = timeout_reg;
  assign cycle_count   = cycle_reg;

`ifndef SYNTHESIS
  // Replaces the old per-event $finish calls scattered through the core:
  // one banner, green for a good trap, red for anything else.
  always @(posedge clock) begin
    if (!reset && SIM_REPORT && (state_reg == ST_REPORT)) begin
      if ((cause_reg == CAUSE_EBREAK) && (exit_reg == 32'd0)) begin
        $display("\033[1;32m[halt] cause=%0d pc=0x%08h exit_code=0x%08h cycles=%0d\033[0m",
                 cause_reg, pc_reg, exit_reg, cycle_reg);
      end else begin
        $display("\033[1;31m[halt] cause=%0d pc=0x%08h exit_code=0x%08h cycles=%0d timeout=%0d\033[0m",
                 cause_reg, pc_reg, exit_reg, cycle_reg, timeout_reg);
      end
      $finish;
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_23060246_halt_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ysyx_23060246_halt_ctrl
//   Directed bench for the halt controller. Instance A (DRAIN_TIMEOUT=8,
//   WDOG_CYCLES=16) takes all directed stimulus and is compared every cycle
//   against a timestamp model; instance B (WDOG_CYCLES=0) idles without any
//   commit for the whole run and must never halt.
// ---------------------------------------------------------------------------
module tb_ysyx_23060246_halt_ctrl;

  localparam int DT = 8;
  localparam int WD = 16;

  logic clock;
  logic reset;
  logic rst_b;
  logic ebreak_valid;
  logic [31:0] a0_value;
  logic inst_invalid;
  logic [31:0] inst_pc;
  logic commit_valid;

  logic        fetch_stall, halt_valid, halted, drain_timeout;
  logic [2:0]  halt_cause;
  logic [31:0] exit_code, halt_pc;
  logic [63:0] cycle_count;

  logic        b_fetch_stall, b_halt_valid, b_halted, b_drain_timeout;
  logic [2:0]  b_halt_cause;
  logic [31:0] b_exit_code, b_halt_pc;
  logic [63:0] b_cycle_count;

  ysyx_23060246_halt_ctrl_if #(.OUTST_W(4)) bus_a ();
  ysyx_23060246_halt_ctrl_if #(.OUTST_W(4)) bus_b ();

  ysyx_23060246_halt_ctrl #(
    .OUTST_W(4), .DRAIN_TIMEOUT(DT), .WDOG_CYCLES(WD), .SIM_REPORT(1'b0)
  ) dut (
    .clock(clock), .reset(reset), .ebreak_valid(ebreak_valid), .a0_value(a0_value),
    .inst_invalid(inst_invalid), .inst_pc(inst_pc), .commit_valid(commit_valid),
    .axi(bus_a), .fetch_stall(fetch_stall), .halt_valid(halt_valid), .halted(halted),
    .halt_cause(halt_cause), .exit_code(exit_code), .halt_pc(halt_pc),
    .drain_timeout(drain_timeout), .cycle_count(cycle_count)
  );

  ysyx_23060246_halt_ctrl #(
    .OUTST_W(4), .DRAIN_TIMEOUT(DT), .WDOG_CYCLES(0), .SIM_REPORT(1'b0)
  ) dut_nowdog (
    .clock(clock), .reset(rst_b), .ebreak_valid(1'b0), .a0_value(32'd0),
    .inst_invalid(1'b0), .inst_pc(32'd0), .commit_valid(1'b0),
    .axi(bus_b), .fetch_stall(b_fetch_stall), .halt_valid(b_halt_valid), .halted(b_halted),
    .halt_cause(b_halt_cause), .exit_code(b_exit_code), .halt_pc(b_halt_pc),
    .drain_timeout(b_drain_timeout), .cycle_count(b_cycle_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int cur   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cur);
    end
  endtask

  // ---------------- behavioural model (timestamps, not states) ----------
  // m_ev  : cycle whose event was accepted (-1 none yet)
  // m_rep : cycle in which the single report pulse appears (-1 unknown)
  // m_wbase: first cycle of the current commit-free stretch
  bit          m_valid = 1'b0;
  int          m_cyc, m_ev, m_rep, m_wbase;
  logic [2:0]  m_cause;
  logic [31:0] m_exit, m_pc;
  logic        m_to;

  always @(posedge clock) begin : model
    int c;
    int cause;
    bit wd;
    if (reset) begin
      m_valid <= 1'b1; m_cyc <= 0; m_ev <= -1; m_rep <= -1; m_wbase <= 0;
      m_cause <= '0; m_exit <= '0; m_pc <= '0; m_to <= 1'b0;
    end else if (m_valid) begin
      c = m_cyc;
      if (m_ev < 0) begin
        wd = (WD != 0) && (c - m_wbase == WD - 1);
        if (bus_a.rresp_valid && bus_a.rresp[1])      cause = 4;
        else if (bus_a.bresp_valid && bus_a.bresp[1]) cause = 3;
        else if (inst_invalid)                        cause = 2;
        else if (ebreak_valid)                        cause = 1;
        else if (wd)                                  cause = 5;
        else                                          cause = 0;
        if (cause != 0) begin
          m_ev    <= c;
          m_cause <= 3'(cause);
          m_exit  <= (cause == 1) ? a0_value : 32'(cause);
          m_pc    <= inst_pc;
        end else if (commit_valid) begin
          m_wbase <= c + 1;
        end
      end else if (m_rep < 0) begin
        if (bus_a.axi_outstanding == 4'd0) begin
          m_rep <= c + 1;
        end else if (c - m_ev == DT) begin
          m_rep <= c + 1;
          m_to  <= 1'b1;
        end
      end
      m_cyc <= c + 1;
    end
  end

  bit b_valid = 1'b0;
  int bcyc;
  always @(posedge clock) begin
    if (rst_b) begin
      b_valid <= 1'b1;
      bcyc    <= 0;
    end else if (b_valid) begin
      bcyc <= bcyc + 1;
    end
  end

  // ---------------- per-cycle compare ----------------------------------
  always @(negedge clock) begin
    if (m_valid) begin
      chk("fetch_stall", 64'(fetch_stall), 64'(m_ev >= 0));
      chk("halt_valid", 64'(halt_valid), 64'(m_rep >= 0 && m_cyc == m_rep));
      chk("halted", 64'(halted), 64'(m_rep >= 0 && m_cyc > m_rep));
      chk("halt_cause", 64'(halt_cause), 64'(m_cause));
      chk("exit_code", 64'(exit_code), 64'(m_exit));
      chk("halt_pc", 64'(halt_pc), 64'(m_pc));
      chk("drain_timeout", 64'(drain_timeout), 64'(m_to));
      chk("cycle_count", cycle_count, 64'((m_rep >= 0) ? m_rep : m_cyc));
    end
    if (b_valid) begin
      chk("nowdog.halted", 64'(b_halted), 64'd0);
      chk("nowdog.fetch_stall", 64'(b_fetch_stall), 64'd0);
      chk("nowdog.cycle_count", b_cycle_count, 64'(bcyc));
    end
  end

  // ---------------- stimulus helpers -----------------------------------
  task automatic next_cycle();
    @(posedge clock);
    #2;
    cur++;
    inst_pc = 32'h8000_0000 + (32'(cur) << 2);
    ebreak_valid = 1'b0;
    inst_invalid = 1'b0;
    bus_a.bresp_valid = 1'b0;
    bus_a.rresp_valid = 1'b0;
  endtask

  task automatic run_to(input int n);
    while (cur < n) next_cycle();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    commit_valid = 1'b0;
    a0_value = '0;
    bus_a.axi_outstanding = '0;
    bus_a.bresp = '0;
    bus_a.rresp = '0;
    next_cycle();
    next_cycle();
    reset = 1'b0;
    cur = 0;
    inst_pc = 32'h8000_0000;
  endtask

  initial begin
    reset = 1'b1; rst_b = 1'b1;
    ebreak_valid = 0; a0_value = 0; inst_invalid = 0; inst_pc = 0; commit_valid = 0;
    bus_a.bresp_valid = 0; bus_a.bresp = 0; bus_a.rresp_valid = 0; bus_a.rresp = 0;
    bus_a.axi_outstanding = 0;
    bus_b.bresp_valid = 0; bus_b.bresp = 0; bus_b.rresp_valid = 0; bus_b.rresp = 0;
    bus_b.axi_outstanding = 0;

    // 1: ebreak at cycle 10, idle bus
    do_reset();
    rst_b = 1'b0;
    @(negedge clock);
    chk("reset.cause", 64'(halt_cause), 64'd0);
    chk("reset.cycle_count", cycle_count, 64'd0);
    commit_valid = 1'b1;
    run_to(10); ebreak_valid = 1'b1; a0_value = 32'd0;
    run_to(11); @(negedge clock);
    chk("ebreak.stall_n1", 64'(fetch_stall), 64'd1);
    chk("ebreak.valid_n1", 64'(halt_valid), 64'd0);
    run_to(12); @(negedge clock);
    chk("ebreak.valid_n2", 64'(halt_valid), 64'd1);
    chk("ebreak.cause", 64'(halt_cause), 64'd1);
    chk("ebreak.exit", 64'(exit_code), 64'd0);
    chk("ebreak.pc", 64'(halt_pc), 64'h8000_0028);
    run_to(13); @(negedge clock);
    chk("ebreak.halted_n3", 64'(halted), 64'd1);
    chk("ebreak.cycles_frozen", cycle_count, 64'd12);

    // 2: rerr + ebreak + invalid together -> rerr wins
    do_reset();
    commit_valid = 1'b1;
    run_to(3);
    bus_a.rresp_valid = 1'b1; bus_a.rresp = 2'b10;
    ebreak_valid = 1'b1; a0_value = 32'd7; inst_invalid = 1'b1;
    run_to(4); @(negedge clock);
    chk("prio.cause", 64'(halt_cause), 64'd4);
    chk("prio.exit", 64'(exit_code), 64'd4);
    chk("prio.pc", 64'(halt_pc), 64'h8000_000C);
    run_to(6); @(negedge clock);
    chk("prio.halted", 64'(halted), 64'd1);

    // 3: invalid with 3 outstanding for 5 cycles, then drained
    do_reset();
    commit_valid = 1'b1;
    run_to(2); inst_invalid = 1'b1; bus_a.axi_outstanding = 4'd3;
    run_to(6); @(negedge clock);
    chk("drain.stall", 64'(fetch_stall), 64'd1);
    chk("drain.no_report", 64'(halt_valid), 64'd0);
    run_to(7); bus_a.axi_outstanding = 4'd0;
    run_to(8); @(negedge clock);
    chk("drain.report", 64'(halt_valid), 64'd1);
    chk("drain.cause", 64'(halt_cause), 64'd2);
    chk("drain.timeout", 64'(drain_timeout), 64'd0);

    // 4: outstanding stuck at 1 -> timeout after 8 drain cycles; BERR ignored
    do_reset();
    commit_valid = 1'b1; bus_a.axi_outstanding = 4'd1;
    run_to(1); inst_invalid = 1'b1;
    run_to(4); bus_a.bresp_valid = 1'b1; bus_a.bresp = 2'b11;
    run_to(5); @(negedge clock);
    chk("sticky.cause", 64'(halt_cause), 64'd2);
    run_to(9); @(negedge clock);
    chk("tmo.no_report", 64'(halt_valid), 64'd0);
    run_to(10); @(negedge clock);
    chk("tmo.report", 64'(halt_valid), 64'd1);
    chk("tmo.flag", 64'(drain_timeout), 64'd1);
    run_to(12); @(negedge clock);
    chk("tmo.cycles_frozen", cycle_count, 64'd10);

    // reset from HALTED, then a normal ebreak
    do_reset();
    @(negedge clock);
    chk("rst_halted.halted", 64'(halted), 64'd0);
    chk("rst_halted.timeout", 64'(drain_timeout), 64'd0);
    chk("rst_halted.exit", 64'(exit_code), 64'd0);
    commit_valid = 1'b1;
    run_to(1); ebreak_valid = 1'b1; a0_value = 32'd0;
    run_to(3); @(negedge clock);
    chk("rst_halted.rehalt", 64'(halt_valid), 64'd1);

    // 5: watchdog without commits fires at cycle 15
    do_reset();
    run_to(15); @(negedge clock);
    chk("wdog.not_yet", 64'(fetch_stall), 64'd0);
    run_to(16); @(negedge clock);
    chk("wdog.cause", 64'(halt_cause), 64'd5);
    chk("wdog.exit", 64'(exit_code), 64'd5);
    chk("wdog.pc", 64'(halt_pc), 64'h8000_003C);
    run_to(17); @(negedge clock);
    chk("wdog.report", 64'(halt_valid), 64'd1);

    // commit every 10 cycles keeps it quiet; last kick at 59 -> fires at 75
    do_reset();
    while (cur < 60) begin
      commit_valid = (cur % 10 == 9);
      next_cycle();
    end
    commit_valid = 1'b0;
    @(negedge clock);
    chk("wdog_kick.no_halt", 64'(fetch_stall), 64'd0);
    run_to(75); @(negedge clock);
    chk("wdog_kick.edge", 64'(fetch_stall), 64'd0);
    run_to(76); @(negedge clock);
    chk("wdog_kick.cause", 64'(halt_cause), 64'd5);
    chk("wdog_kick.pc", 64'(halt_pc), 64'h8000_012C);

    // 6: reset mid-DRAIN, then new ebreak with nonzero a0
    do_reset();
    commit_valid = 1'b1; bus_a.axi_outstanding = 4'd2;
    run_to(1); ebreak_valid = 1'b1; a0_value = 32'd5;
    run_to(3); @(negedge clock);
    chk("middrain.stall", 64'(fetch_stall), 64'd1);
    do_reset();
    @(negedge clock);
    chk("middrain.rst_stall", 64'(fetch_stall), 64'd0);
    chk("middrain.rst_cause", 64'(halt_cause), 64'd0);
    chk("middrain.rst_pc", 64'(halt_pc), 64'd0);
    commit_valid = 1'b1;
    run_to(2); ebreak_valid = 1'b1; a0_value = 32'h2a;
    run_to(4); @(negedge clock);
    chk("middrain.report", 64'(halt_valid), 64'd1);
    chk("middrain.exit", 64'(exit_code), 64'h2a);
    run_to(6);
    @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
